// File: rtl/alu_bist.sv
// ---------------------------------------------------------------------------
// alu_bist -- built-in self-test sequencer for the 1-bit ALU (M,S1,S0,A,B -> F)
//
// It walks all 32 input vectors in order. Each vector is held for SETTLE
// cycles, then F is compared against the golden table EXPECTED on one CHECK
// cycle. It reports the mismatch count, the lowest failing vector and
// pass/fail.
//
// Parameters
//   SETTLE    cycles a vector is held before F is sampled (1..15)
//   EXPECTED  golden table, bit i = expected F for vector i = {M,S1,S0,A,B}
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous, active-high; wins over start
//   start             sweep request, sampled in IDLE and DONE only
//   f                 ALU result returned to the block
//   m,s1,s0,a,b       vector driven to the ALU (idx[4:0], MSB first)
//   busy              high in SETTLE and CHECK
//   done              high in DONE, held until the next start or reset
//   pass              high in DONE when no vector mismatched
//   err_count         number of mismatching vectors (0..32)
//   first_fail        index of the lowest failing vector
//   first_fail_valid  first_fail holds a real index
// ---------------------------------------------------------------------------
module alu_bist #(
   parameter int unsigned SETTLE   = 2,
   parameter logic [31:0] EXPECTED = 32'hC36636E8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       f,
   output logic       m,
   output logic       s1,
   output logic       s0,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [5:0] err_count,
   output logic [4:0] first_fail,
   output logic       first_fail_valid
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   // Settle counter runs 0..SETTLE-1, so SETTLE=15 still fits in 4 bits.
   localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

   state_t     state_q;
   logic [4:0] idx_q;
   logic [3:0] cnt_q;
   logic [5:0] err_q;
   logic [5:0] err_d;
   logic [4:0] ff_q;
   logic       ffv_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic       mismatch;
   logic       last_vec;

   // Only meaningful in CHECK; idx_q has been stable since SETTLE began.
   always_comb begin
      mismatch = (f != EXPECTED[idx_q]);
      err_d    = err_q + {5'd0, mismatch};
      last_vec = (idx_q == 5'd31);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ff_q    <= '0;
         ffv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         case (state_q)
            // A start from DONE behaves exactly like one from IDLE, which
            // also drops done/pass on the following cycle.
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_SETTLE;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  err_q   <= '0;
                  ff_q    <= '0;
                  ffv_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end
            end

            S_SETTLE: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_CHECK;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end

            S_CHECK: begin
               err_q <= err_d;
               if (mismatch && !ffv_q) begin
                  ff_q  <= idx_q;
                  ffv_q <= 1'b1;
               end
               if (last_vec) begin
                  // idx stays at 31: the sweep never wraps.
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == 6'd0);
               end else begin
                  idx_q   <= idx_q + 5'd1;
                  state_q <= S_SETTLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   // idx_q is itself a register, so the vector pins are registered outputs.
   assign {m, s1, s0, a, b}  = idx_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign pass               = pass_q;
   assign err_count          = err_q;
   assign first_fail         = ff_q;
   assign first_fail_valid   = ffv_q;

endmodule

// File: tb/tb_alu_bist.sv
// ---------------------------------------------------------------------------
// tb_alu_bist -- bench for alu_bist. A behavioural ALU answers the BIST's
// vectors; a per-vector fault mask flips chosen answers. Expected results
// come from the mask (popcount, lowest set bit) and the sweep timing rules.
// ---------------------------------------------------------------------------
module tb_alu_bist;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       f;
   logic       m, s1, s0, a, b;
   logic       busy, done, pass;
   logic [5:0] err_count;
   logic [4:0] first_fail;
   logic       first_fail_valid;

   logic [31:0] fault_mask = '0;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   alu_bist dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .f                (f),
      .m                (m),
      .s1               (s1),
      .s0               (s0),
      .a                (a),
      .b                (b),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .err_count        (err_count),
      .first_fail       (first_fail),
      .first_fail_valid (first_fail_valid)
   );

   // Behavioural 1-bit ALU written from the operation list.
   function automatic logic alu(input logic mm, input logic [1:0] s,
                                input logic aa, input logic bb);
      if (!mm) begin
         case (s)
            2'b00:   return aa & bb;
            2'b01:   return aa | bb;
            2'b10:   return aa ^ bb;
            default: return ~aa;
         endcase
      end else begin
         case (s)
            2'b00, 2'b01: return aa ^ bb;
            2'b10:        return ~aa;
            default:      return aa;
         endcase
      end
   endfunction

   always_comb begin
      f = alu(m, {s1, s0}, a, b) ^ fault_mask[{m, s1, s0, a, b}];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] golden_table();
      logic [31:0] t;
      for (int i = 0; i < 32; i++) begin
         logic [4:0] v;
         v = 5'(i);
         t[i] = alu(v[4], v[3:2], v[1], v[0]);
      end
      return t;
   endfunction

   function automatic logic [19:0] outs();
      return {m, s1, s0, a, b, busy, done, pass, err_count, first_fail, first_fail_valid};
   endfunction

   // One full sweep with the given fault mask. start is pulsed for one
   // cycle; optionally re-pulsed mid-sweep at cycle restart_at.
   // Observations are taken at negedges: c = cycles after the start edge.
   task automatic sweep(input string tag, input logic [31:0] fm, input int restart_at);
      int          c, busy_n, vchg, lat, pc, lo;
      logic        order_ok;
      logic [4:0]  prev, cur;
      fault_mask = fm;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      c = 0; busy_n = 0; vchg = 0; order_ok = 1'b1; prev = 5'd0;
      chk({tag, "_vec0"}, {27'd0, m, s1, s0, a, b}, 32'd0);
      chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
      while (!done && c < 200) begin
         if (busy) busy_n++;
         cur = {m, s1, s0, a, b};
         if (cur != prev) begin
            vchg++;
            if (cur != prev + 5'd1) order_ok = 1'b0;
            prev = cur;
         end
         if (c == restart_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         c++;
      end
      // done becomes visible to the edge following update c, i.e. k+c+1.
      lat = c + 1;
      pc = 0; lo = -1;
      for (int i = 31; i >= 0; i--) if (fm[i]) begin pc++; lo = i; end
      chk({tag, "_latency"}, lat, 97);
      chk({tag, "_busy_cycles"}, busy_n, 96);
      chk({tag, "_vec_steps"}, {vchg, 31'(order_ok)}, {31, 31'd1});
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, "_err"}, {26'd0, err_count}, pc);
      chk({tag, "_pass"}, {31'd0, pass}, {31'd0, pc == 0});
      chk({tag, "_ffv"}, {31'd0, first_fail_valid}, {31'd0, pc != 0});
      if (pc != 0) chk({tag, "_ff"}, {27'd0, first_fail}, lo);
   endtask

   initial begin
      logic [31:0] gt, rm;

      // Model sanity against the documented table.
      gt = golden_table();
      chk("golden_tbl", gt, 32'hC36636E8);

      // Reset held with start asserted: reset wins, everything stays 0.
      reset = 1'b1; start = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("reset_hold", {12'd0, outs()}, 32'd0);
      end
      reset = 1'b0; start = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("reset_rel", {12'd0, outs()}, 32'd0);
      end

      sweep("good",    32'd0, -1);
      sweep("stuck0",  gt,    -1);
      sweep("stuck1",  ~gt,   -1);
      sweep("vec21",   32'd1 << 21, -1);
      sweep("restart40", 32'd0, 40);

      // Results hold in DONE while start stays low.
      sweep("hold", 32'h0000_0300, -1);
      repeat (3) @(negedge clk);
      chk("hold_done", {26'd0, done, err_count}, {26'd0, 1'b1, 6'd2});
      chk("hold_ff", {26'd0, first_fail_valid, first_fail}, {26'd0, 1'b1, 5'd8});

      // Start from DONE restarts and clears err_count.
      sweep("redone", 32'd0, -1);

      // Reset mid-sweep, then a clean sweep.
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (50) @(negedge clk);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      chk("mid_reset", {12'd0, outs()}, 32'd0);
      @(negedge clk);
      chk("mid_idle", {12'd0, outs()}, 32'd0);
      sweep("after_rst", 32'd0, -1);

      // Randomized fault masks, dense and sparse.
      for (int r = 0; r < 6; r++) begin
         rm = $urandom();
         if (r[0]) rm = rm & $urandom() & $urandom();
         if (r == 4) rm = 32'h8000_0000;
         sweep($sformatf("rnd%0d", r), rm, (r == 2) ? int'($urandom_range(1, 90)) : -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_bist.md
# alu_bist

Self-test sequencer for the 1-bit ALU (M, S1, S0, A, B → F). It replaces the exhaustive simulation sweep with synthesizable hardware that drives the ALU's inputs and checks its output.

- Applies all 32 input vectors to the ALU in order.
- Samples F after a programmable settle time and compares it against a golden truth table.
- Reports the error count, the first failing vector, and pass/fail.
- Sits beside the ALU: the block's vector outputs feed the ALU's inputs, and the ALU's F returns to the block.

## Interface
Parameters:
- SETTLE, default 2: cycles a vector is held before F is sampled. Legal range 1–15.
- EXPECTED, default 32'hC36636E8: golden table. Bit i is the expected F for vector i, where i = {M,S1,S0,A,B}.
  - M=0, S1S0 = 00/01/10/11: AND, OR, XOR, NOT A.
  - M=1, S1S0 = 00/01/10/11: XOR, XOR, NOT A, A.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- start  in  1  request to run a sweep; sampled in IDLE and DONE only.
- f  in  1  ALU result.
- m, s1, s0, a, b  out  1 each  vector driven to the ALU; equal to idx[4:0] MSB-first.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  high in DONE when err_count == 0; 0 elsewhere.
- err_count  out  6  number of mismatching vectors, range 0–32.
- first_fail  out  5  index of the lowest failing vector.
- first_fail_valid  out  1  first_fail holds a real index.

## Operation
- Internal state: 5-bit vector index idx, 4-bit settle counter cnt, FSM.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 → idx←0, cnt←0, err_count←0, first_fail←0, first_fail_valid←0, go to SETTLE.
- SETTLE:
  - cnt increments every cycle.
  - When cnt == SETTLE-1 → go to CHECK, cnt←0.
- CHECK: compare f with EXPECTED[idx].
  - Mismatch → err_count += 1.
  - Mismatch while first_fail_valid=0 → first_fail←idx and first_fail_valid←1.
  - idx == 31 → go to DONE.
  - Otherwise → idx += 1, go to SETTLE.
- DONE: done=1, pass=(err_count==0).
  - err_count, first_fail and first_fail_valid hold their values.
  - start=1 → restart exactly as from IDLE; done drops on the next cycle.
- Vector outputs are registered from idx. They are stable through SETTLE and CHECK for every vector.
- Counters:
  - err_count saturates naturally at 32 because there are exactly 32 checks; no overflow is possible.
  - idx does not wrap during a sweep.
- start while busy (SETTLE or CHECK): ignored; the sweep is not restarted.
- reset at any cycle, including mid-sweep:
  - Next cycle: IDLE, idx=0, cnt=0.
  - All outputs 0: m,s1,s0,a,b=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0.
- reset and start in the same cycle: reset wins.

## Timing
- busy = 1 in SETTLE and CHECK. It rises the cycle after start is sampled and falls when DONE is entered.
- Each vector takes SETTLE + 1 cycles; F is sampled on the CHECK cycle.
- A full sweep takes 32 × (SETTLE + 1) cycles. done rises on the cycle after the final CHECK.
- start is sampled at edge k → done is high from edge k + 32 × (SETTLE + 1) + 1. With the default SETTLE=2, that is edge k+97.
- The ALU is combinational. F must settle within SETTLE clock periods of a vector change.
- No other handshake exists; start is level-sampled.

## Test plan
- Reset: hold reset for 2 cycles with start=1 → every output reads 0 and the state is IDLE; release reset with start=0 → outputs stay 0.
- Good ALU (behavioural golden model of EXPECTED on f), start pulsed 1 cycle → busy for 96 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0, done at start-edge+97.
- F stuck at 0 → err_count=16 (the popcount of EXPECTED), first_fail=3, first_fail_valid=1, pass=0.
- F stuck at 1 → err_count=16, first_fail=0, pass=0.
- Golden model with vector 21 (M=1, S1=0, S0=1, A=0, B=1) inverted → err_count=1, first_fail=21, pass=0.
- Sequencing:
  - start re-pulsed at cycle 40 of a sweep → no effect; done still at +97.
  - reset at cycle 50 → all outputs 0 next cycle.
  - A subsequent start runs a clean full sweep.
  - start in DONE restarts and clears err_count.
